vote_session_ctrl: RTL and testbench

- Session controller and booth arbiter placed in front of the one-hot vote counter datapath.
- Collects ballots from NUM_BOOTHS voting booths and grants them round-robin access to the single counter increment port.
- Sequences poll phases IDLE -> OPEN -> CLOSED -> CLEARING and drives the counter clear.
- Each accepted ballot produces exactly one increment pulse at the counter.

---
 rtl/vote_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/vote_session_ctrl.sv | 146 ++++++++++++++
 tb/tb_vote_session_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the vote session controller.
//   VOTE_CNT_W   : width of the accepted-ballot counter
//   poll_state_e : poll phase encoding (also the poll_state output encoding)
//   is_onehot()  : true when exactly one bit of the argument is set
package vote_pkg;

  localparam int unsigned VOTE_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_OPEN     = 2'b01,
    ST_CLOSED   = 2'b10,
    ST_CLEARING = 2'b11
  } poll_state_e;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered search-start pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   advance    : the current grant was consumed; move pointer past it
//   grant      : one-hot grant (combinational), grant_vld when any req
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         grant_vld
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gidx;

  // Scan N positions starting at ptr_q, wrapping modulo N; first hit wins.
  always_comb begin : p_search
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    grant     = '0;
    grant_vld = 1'b0;
    gidx      = ptr_q;
    sum       = '0;
    idx       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_vld) begin
      ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vote_session_ctrl.sv
// Poll session controller and booth arbiter in front of the vote counter.
//   open_poll/close_poll/clear : phase control pulses
//   booth_req/booth_cand       : per-booth level request and one-hot ballot
//   booth_ack/booth_nack       : registered 1-cycle decision pulses
//   cnt_ready/cnt_inc/cnt_sel  : counter increment handshake
//   cnt_clr                    : counter clear strobe (high while CLEARING)
//   poll_state/total_votes/poll_full : session status
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned NUM_BOOTHS = 4,
  parameter int unsigned NUM_CAND   = 4,
  parameter int unsigned MAX_VOTES  = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         open_poll,
  input  logic                         close_poll,
  input  logic                         clear,
  input  logic [NUM_BOOTHS-1:0]        booth_req,
  input  logic [NUM_BOOTHS*NUM_CAND-1:0] booth_cand,
  output logic [NUM_BOOTHS-1:0]        booth_ack,
  output logic [NUM_BOOTHS-1:0]        booth_nack,
  input  logic                         cnt_ready,
  output logic                         cnt_inc,
  output logic [NUM_CAND-1:0]          cnt_sel,
  output logic                         cnt_clr,
  output logic [1:0]                   poll_state,
  output logic [VOTE_CNT_W-1:0]        total_votes,
  output logic                         poll_full
);

  localparam logic [VOTE_CNT_W-1:0] MaxVotes = VOTE_CNT_W'(MAX_VOTES);

  poll_state_e               state_q, state_d;
  logic [NUM_BOOTHS-1:0]     lock_q, lock_d, ack_q, ack_d, nack_q, nack_d;
  logic [NUM_BOOTHS-1:0]     eligible, grant;
  logic                      grant_vld, decide;
  logic                      inc_q, inc_d, clr_q, clr_d;
  logic [NUM_CAND-1:0]       sel_q, sel_d, ballot;
  logic [VOTE_CNT_W-1:0]     total_q, total_d;
  logic                      ballot_ok;

  // Locked booths already got their decision for the current request.
  assign eligible = booth_req & ~lock_q;

  rr_arbiter #(
    .N (NUM_BOOTHS)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (eligible),
    .advance   (decide),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  always_comb begin
    ballot = '0;
    for (int unsigned i = 0; i < NUM_BOOTHS; i++) begin
      if (grant[i]) ballot = booth_cand[i*NUM_CAND +: NUM_CAND];
    end
  end

  assign ballot_ok = is_onehot(32'(ballot));

  always_comb begin
    ack_d   = '0;
    nack_d  = '0;
    inc_d   = 1'b0;
    sel_d   = '0;
    clr_d   = 1'b0;
    total_d = total_q;
    state_d = state_q;

    if (grant_vld) begin
      if (state_q == ST_OPEN) begin
        if (!ballot_ok) begin
          nack_d = grant;
        end else if (cnt_ready && !close_poll) begin
          // A coincident close_poll leaves a valid ballot pending; it is
          // nacked later from CLOSED.
          ack_d   = grant;
          inc_d   = 1'b1;
          sel_d   = ballot;
          total_d = total_q + 1'b1;
        end
      end else begin
        nack_d = grant;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (open_poll)  state_d = ST_OPEN;
        else if (clear) state_d = ST_CLEARING;
      end
      // Closing on the capping accept itself keeps any later accept impossible.
      ST_OPEN:     if (close_poll || (inc_d && total_d == MaxVotes)) state_d = ST_CLOSED;
      ST_CLOSED:   if (clear) state_d = ST_CLEARING;
      ST_CLEARING: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (state_d == ST_CLEARING) begin
      total_d = '0;
      clr_d   = 1'b1;
    end
  end

  assign decide = |(ack_d | nack_d);
  // Lock holds while the request stays high; drops once req is seen low.
  assign lock_d = booth_req & (lock_q | ack_d | nack_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      ack_q   <= '0;
      nack_q  <= '0;
      inc_q   <= 1'b0;
      sel_q   <= '0;
      clr_q   <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      inc_q   <= inc_d;
      sel_q   <= sel_d;
      clr_q   <= clr_d;
      total_q <= total_d;
    end
  end

  assign booth_ack   = ack_q;
  assign booth_nack  = nack_q;
  assign cnt_inc     = inc_q;
  assign cnt_sel     = sel_q;
  assign cnt_clr     = clr_q;
  assign poll_state  = state_q;
  assign total_votes = total_q;
  assign poll_full   = (total_q == MaxVotes);

endmodule

// File: tb/tb_vote_session_ctrl.sv
module tb_vote_session_ctrl;

  localparam int NB  = 4;
  localparam int NC  = 4;
  localparam int MAX = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          open_poll = 1'b0, close_poll = 1'b0, clear = 1'b0;
  logic [NB-1:0] booth_req = '0;
  logic [NB*NC-1:0] booth_cand = '0;
  logic [NB-1:0] booth_ack, booth_nack;
  logic          cnt_ready = 1'b1;
  logic          cnt_inc;
  logic [NC-1:0] cnt_sel;
  logic          cnt_clr;
  logic [1:0]    poll_state;
  logic [7:0]    total_votes;
  logic          poll_full;

  int n_total = 0;
  int n_bad   = 0;

  vote_session_ctrl #(
    .NUM_BOOTHS (NB),
    .NUM_CAND   (NC),
    .MAX_VOTES  (MAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .open_poll   (open_poll),
    .close_poll  (close_poll),
    .clear       (clear),
    .booth_req   (booth_req),
    .booth_cand  (booth_cand),
    .booth_ack   (booth_ack),
    .booth_nack  (booth_nack),
    .cnt_ready   (cnt_ready),
    .cnt_inc     (cnt_inc),
    .cnt_sel     (cnt_sel),
    .cnt_clr     (cnt_clr),
    .poll_state  (poll_state),
    .total_votes (total_votes),
    .poll_full   (poll_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ack"},   32'(booth_ack), 0);
    chk({pfx, "_nack"},  32'(booth_nack), 0);
    chk({pfx, "_inc"},   32'(cnt_inc), 0);
    chk({pfx, "_sel"},   32'(cnt_sel), 0);
    chk({pfx, "_clr"},   32'(cnt_clr), 0);
    chk({pfx, "_state"}, 32'(poll_state), 0);
    chk({pfx, "_total"}, 32'(total_votes), 0);
    chk({pfx, "_full"},  32'(poll_full), 0);
  endtask

  // Reference bookkeeping for the randomized sessions.
  logic [NB-1:0] rq;
  int            gap[NB];
  int            wait_cyc[NB];
  int            model_total;
  logic          ready_prev;
  logic [NC-1:0] bal;
  int            n_acks, n_incs;

  initial begin
    // Reset values
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Four booths at once: acks in order 0..3
    open_poll = 1'b1; tick(); open_poll = 1'b0;
    chk("open_state", 32'(poll_state), 1);
    booth_cand = 16'h8421;
    booth_req  = 4'hf;
    for (int i = 0; i < NB; i++) begin
      tick();
      chk("rr_ack", 32'(booth_ack), 32'(1 << i));
      chk("rr_sel", 32'(cnt_sel), 32'(1 << i));
      chk("rr_inc", 32'(cnt_inc), 1);
      booth_req[i] = 1'b0;
    end
    chk("rr_total", 32'(total_votes), 4);

    // Held request: one decision only until req drops
    booth_cand[7:4] = 4'b0001;
    booth_req[1] = 1'b1;
    n_acks = 0; n_incs = 0;
    repeat (10) begin
      tick();
      n_acks += int'(booth_ack[1]);
      n_incs += int'(cnt_inc);
    end
    chk("hold_acks", 32'(n_acks), 1);
    chk("hold_incs", 32'(n_incs), 1);
    booth_req[1] = 1'b0; tick();
    booth_req[1] = 1'b1; tick();
    chk("rereq_ack", 32'(booth_ack), 32'b0010);
    chk("rereq_sel", 32'(cnt_sel), 32'b0001);
    booth_req[1] = 1'b0;
    tick();
    chk("rereq_total", 32'(total_votes), 6);

    // Multi-hot ballot rejected
    booth_cand[3:0] = 4'b0011;
    booth_req[0] = 1'b1;
    tick();
    chk("bad_nack", 32'(booth_nack), 32'b0001);
    chk("bad_inc", 32'(cnt_inc), 0);
    chk("bad_total", 32'(total_votes), 6);
    booth_req[0] = 1'b0; tick();

    // Counter not ready: ballot waits
    cnt_ready = 1'b0;
    booth_cand[11:8] = 4'b0100;
    booth_req[2] = 1'b1;
    repeat (3) begin
      tick();
      chk("stall_none", 32'({booth_ack, booth_nack}), 0);
    end
    cnt_ready = 1'b1;
    tick();
    chk("stall_ack", 32'(booth_ack), 32'b0100);
    chk("stall_sel", 32'(cnt_sel), 32'b0100);
    chk("stall_total", 32'(total_votes), 7);
    booth_req[2] = 1'b0; tick();

    // close_poll beats a coincident valid ballot
    booth_cand[15:12] = 4'b1000;
    booth_req[3] = 1'b1;
    close_poll = 1'b1;
    tick();
    close_poll = 1'b0;
    chk("close_inc", 32'(cnt_inc), 0);
    chk("close_ack", 32'(booth_ack), 0);
    chk("close_state", 32'(poll_state), 2);
    tick();
    chk("close_nack", 32'(booth_nack), 32'b1000);
    chk("close_total", 32'(total_votes), 7);
    booth_req[3] = 1'b0; tick();

    // Clear sequence
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_state", 32'(poll_state), 3);
    chk("clr_pulse", 32'(cnt_clr), 1);
    chk("clr_total", 32'(total_votes), 0);
    tick();
    chk("clr_idle", 32'(poll_state), 0);
    chk("clr_end", 32'(cnt_clr), 0);

    // Requests in IDLE are nacked, even alongside open_poll
    booth_cand[7:4] = 4'b0010;
    booth_req[1] = 1'b1;
    tick();
    chk("idle_nack", 32'(booth_nack), 32'b0010);
    booth_req[1] = 1'b0;
    booth_req[2] = 1'b1;
    open_poll = 1'b1;
    tick();
    open_poll = 1'b0;
    chk("openreq_nack", 32'(booth_nack), 32'b0100);
    chk("openreq_inc", 32'(cnt_inc), 0);
    chk("openreq_state", 32'(poll_state), 1);
    booth_req[2] = 1'b0;
    close_poll = 1'b1; tick(); close_poll = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    tick();
    chk("back_idle", 32'(poll_state), 0);

    // Randomized sessions against the ballot-rule model
    for (int s = 0; s < 3; s++) begin
      rq = '0;
      model_total = 0;
      for (int b = 0; b < NB; b++) begin gap[b] = 0; wait_cyc[b] = 0; end
      cnt_ready = 1'b1;
      ready_prev = 1'b1;
      booth_req = '0;
      open_poll = 1'b1; tick(); open_poll = 1'b0;
      for (int c = 0; c < 250; c++) begin
        tick();
        chk("rnd_one_dec", 32'($countones(booth_ack | booth_nack) <= 1), 1);
        for (int b = 0; b < NB; b++) begin
          if (booth_ack[b] || booth_nack[b]) begin
            logic [1:0] expv;
            chk("rnd_dec_req", 32'(rq[b]), 1);
            bal = booth_cand[b*NC +: NC];
            if ($countones(bal) != 1 || model_total >= MAX) expv = 2'b01;
            else if (ready_prev)                              expv = 2'b10;
            else                                              expv = 2'b00;
            chk("rnd_decision", 32'({booth_ack[b], booth_nack[b]}), 32'(expv));
            chk("rnd_sel", 32'(cnt_sel), (expv == 2'b10) ? 32'(bal) : 0);
            if (expv == 2'b10) model_total++;
            rq[b] = 1'b0;
            gap[b] = int'($urandom_range(1, 3));
            wait_cyc[b] = 0;
          end
        end
        chk("rnd_inc", 32'(cnt_inc), 32'(|booth_ack));
        chk("rnd_total", 32'(total_votes), 32'(model_total));
        chk("rnd_state", 32'(poll_state), (model_total < MAX) ? 1 : 2);
        chk("rnd_full", 32'(poll_full), 32'(model_total == MAX));
        for (int b = 0; b < NB; b++) begin
          if (rq[b]) begin
            wait_cyc[b]++;
            if (wait_cyc[b] > 100) begin
              chk("rnd_timeout", 0, 1);
              rq[b] = 1'b0;
              wait_cyc[b] = 0;
              gap[b] = 1;
            end
          end else if (gap[b] > 0) begin
            gap[b]--;
          end else if ($urandom_range(0, 2) == 0) begin
            bal = ($urandom_range(0, 9) < 7) ? NC'(1 << $urandom_range(0, NC - 1))
                                             : NC'($urandom);
            booth_cand[b*NC +: NC] = bal;
            rq[b] = 1'b1;
          end
        end
        booth_req = rq;
        cnt_ready = ($urandom_range(0, 3) != 0);
        ready_prev = cnt_ready;
      end
      booth_req = '0;
      cnt_ready = 1'b1;
      tick();
      close_poll = 1'b1; tick(); close_poll = 1'b0;
      clear = 1'b1; tick(); clear = 1'b0;
      chk("rnd_clr_state", 32'(poll_state), 3);
      chk("rnd_clr_total", 32'(total_votes), 0);
      tick();
      chk("rnd_idle", 32'(poll_state), 0);
    end

    // Asynchronous reset in the middle of a vote
    open_poll = 1'b1; tick(); open_poll = 1'b0;
    booth_cand[11:8] = 4'b0100;
    booth_req = 4'b0100;
    tick();
    chk("mid_ack", 32'(booth_ack), 32'b0100);
    chk("mid_total", 32'(total_votes), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_ack", 32'(booth_ack), 0);
    chk("post_rst_nack", 32'(booth_nack), 32'b0100);
    chk("post_rst_state", 32'(poll_state), 0);
    booth_req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
